dual_adc_capture: RTL and testbench
===================================

# dual_adc_capture

Serial capture engine for the two-channel 12-bit ADC Pmod, i.e. the audio input path that mirrors the existing DAC output path. On each sample strobe (the 20 kHz tick) it runs one chip-select frame, generates the serial clock, and shifts in both ADC data lines in parallel. It then presents two 12-bit samples with a one-cycle completion pulse to downstream audio logic. It runs on the 100 MHz system clock alongside the DAC driver.

## Interface
- `DIV`, 4: SCLK half-period in CLK cycles, legal range 2..255. The default gives SCLK = 12.5 MHz.
- `QUIET`, 8: CLK cycles nCS is held high after a frame before the next frame may start, legal range 1..255.
- `CLK` in 1: system clock, 100 MHz, single clock domain.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: sample request, single-cycle pulse.
- `DIN1` in 1: serial data from ADC channel 1.
- `DIN2` in 1: serial data from ADC channel 2.
- `nCS` out 1: ADC chip select, active low.
- `SCLK` out 1: ADC serial clock, idles high.
- `DATA1` out 12: last channel-1 sample.
- `DATA2` out 12: last channel-2 sample.
- `DONE` out 1: one-cycle pulse when DATA1/DATA2 update.
- `BUSY` out 1: high from frame start through the end of the quiet period.
- `OVERRUN` out 1: one-cycle pulse when START arrives during SHIFT.
- `FMT_ERR` out 1: one-cycle pulse, coincident with DONE, if any of the 4 leading bits on either channel was nonzero.

## Operation
- All outputs are registered.
- Reset values: nCS=1, SCLK=1, DATA1=DATA2=0, DONE=0, BUSY=0, OVERRUN=0, FMT_ERR=0. State is IDLE and all counters are 0.
- FSM states are IDLE, SHIFT and QUIET.
- IDLE -> SHIFT when START=1 at a CLK edge in IDLE. At that edge: nCS<=0, BUSY<=1, SCLK stays 1, half-period and bit counters clear.
- SHIFT:
  - A half-period counter counts to DIV and toggles SCLK on expiry.
  - On each 0->1 SCLK toggle, DIN1 and DIN2 are sampled (the values present at that CLK edge) and shifted MSB-first into two 16-bit shift registers. The bit counter increments.
  - The 16th rising toggle ends the frame. On that same edge: nCS<=1, SCLK ends high, DATA1<=sr1[11:0], DATA2<=sr2[11:0], DONE<=1, FMT_ERR<=(sr1[15:12]|sr2[15:12])!=0, state<=QUIET.
- QUIET: nCS stays high for QUIET cycles, then state<=IDLE and BUSY<=0.
- START handling:
  - START in SHIFT is ignored and pulses OVERRUN.
  - START in QUIET is ignored silently and is not latched.
  - START in IDLE on the same edge BUSY falls is not possible, because BUSY falls on entry to IDLE.
- DATA1/DATA2 hold their value between frames. They change only on DONE.
- FMT_ERR does not suppress the data update.
- Width rules:
  - Bit counter is 5 bits; termination is at count 16.
  - Half-period counter is 8 bits.
  - Quiet counter is 8 bits.
  - No wrap-around is reachable within legal parameters.

## Timing
- START sampled at edge t.
- nCS is low for CLK edges t+1 .. t+32·DIV.
- SCLK timing:
  - Falls at t+DIV·(2k+1) for k=0..15.
  - Rises at t+DIV·(2k+2).
  - Last rise at t+32·DIV, together with nCS rising, DONE, DATA update and FMT_ERR.
- Start-to-DONE latency is 32·DIV cycles (128 at default).
- BUSY falls at t+32·DIV+QUIET.
- Minimum START-to-START spacing for accepted frames is 32·DIV+QUIET+1 cycles (137 at default).
- ADC contract: data changes on SCLK falling edges. Each sampling edge sits DIV cycles after the preceding fall.
- RST mid-frame: on the next edge, all outputs take their reset values. DONE is not pulsed and DATA is not updated (DATA returns to 0). The FSM is in IDLE, and a START is accepted on the edge after RST deasserts.
- RST and START both high: RST wins.

## Test plan
- Basic frame:
  - Stimulus: ADC model drives 16'h0ABC on DIN1 and 16'h0123 on DIN2; START pulse at t.
  - Required: DATA1=12'hABC, DATA2=12'h123, single DONE at t+128, FMT_ERR=0, exactly 16 SCLK rising edges while nCS is low.
- Format error:
  - Stimulus: DIN1 word 16'h8FFF, DIN2 16'h0000.
  - Required: DATA1=12'hFFF, DATA2=12'h000, DONE and FMT_ERR both pulse at t+128.
- Overrun:
  - Stimulus: START at t, second START at t+40.
  - Required: OVERRUN pulses at t+41. Only one frame runs (nCS low for exactly 128 cycles). Exactly one DONE.
  - Also: START at t+130 (during QUIET) causes no OVERRUN and no frame.
- Reset mid-frame:
  - Stimulus: after one completed frame with DATA1=12'h555, START at t, RST high for one cycle at t+50.
  - Required: at t+51 nCS=1, SCLK=1, DATA1=0, BUSY=0. No DONE at t+128.
  - Then a START at t+60 yields a full frame with DONE at t+188.
- Back-to-back:
  - Stimulus: START pulses every 137 cycles with alternating words 12'h000 and 12'hFFF.
  - Required: every START is accepted, DONE count equals START count, no OVERRUN, DATA alternates correctly.
- Parameter sweep:
  - Stimulus: DIV=2, QUIET=1.
  - Required: DONE at t+64, SCLK period 4 CLK cycles, BUSY falls at t+65.

Source files
------------

// File: rtl/dual_adc_capture.sv
// dual_adc_capture: runs one nCS/SCLK frame per START and shifts in two 12-bit ADC channels in parallel
module dual_adc_capture #(
    parameter int DIV   = 4,
    parameter int QUIET = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        DIN1,
    input  logic        DIN2,
    output logic        nCS,
    output logic        SCLK,
    output logic [11:0] DATA1,
    output logic [11:0] DATA2,
    output logic        DONE,
    output logic        BUSY,
    output logic        OVERRUN,
    output logic        FMT_ERR
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_QUIET} state_t;

    state_t      state, state_n;
    logic [7:0]  hcnt, hcnt_n, qcnt, qcnt_n;
    logic [4:0]  bcnt, bcnt_n;
    logic [14:0] sr1, sr1_n, sr2, sr2_n;
    logic [11:0] data1_n, data2_n;
    logic        ncs_n, sclk_n, done_n, busy_n, ovr_n, fmt_n;
    logic        expire, rise;
    logic [15:0] sh1, sh2;

    assign expire = hcnt == 8'(DIV - 1);
    assign rise   = expire && !SCLK;
    // Full 16-bit word including the bit sampled on this edge
    assign sh1    = {sr1, DIN1};
    assign sh2    = {sr2, DIN2};

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        qcnt_n  = qcnt;
        bcnt_n  = bcnt;
        sr1_n   = sr1;
        sr2_n   = sr2;
        ncs_n   = nCS;
        sclk_n  = SCLK;
        data1_n = DATA1;
        data2_n = DATA2;
        busy_n  = BUSY;
        done_n  = 1'b0;
        ovr_n   = 1'b0;
        fmt_n   = 1'b0;
        case (state)
            S_IDLE: if (START) begin
                state_n = S_SHIFT;
                ncs_n   = 1'b0;
                busy_n  = 1'b1;
                hcnt_n  = '0;
                bcnt_n  = '0;
            end
            S_SHIFT: begin
                ovr_n  = START;
                hcnt_n = expire ? 8'd0 : hcnt + 8'd1;
                sclk_n = expire ? !SCLK : SCLK;
                if (rise) begin
                    sr1_n  = sh1[14:0];
                    sr2_n  = sh2[14:0];
                    bcnt_n = bcnt + 5'd1;
                end
                if (rise && bcnt == 5'd15) begin
                    state_n = S_QUIET;
                    ncs_n   = 1'b1;
                    data1_n = sh1[11:0];
                    data2_n = sh2[11:0];
                    done_n  = 1'b1;
                    fmt_n   = |{sh1[15:12], sh2[15:12]};
                    qcnt_n  = '0;
                end
            end
            S_QUIET: begin
                qcnt_n = qcnt + 8'd1;
                if (qcnt == 8'(QUIET - 1)) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    qcnt_n  = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            hcnt    <= '0;
            qcnt    <= '0;
            bcnt    <= '0;
            sr1     <= '0;
            sr2     <= '0;
            nCS     <= 1'b1;
            SCLK    <= 1'b1;
            DATA1   <= '0;
            DATA2   <= '0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
            OVERRUN <= 1'b0;
            FMT_ERR <= 1'b0;
        end else begin
            state   <= state_n;
            hcnt    <= hcnt_n;
            qcnt    <= qcnt_n;
            bcnt    <= bcnt_n;
            sr1     <= sr1_n;
            sr2     <= sr2_n;
            nCS     <= ncs_n;
            SCLK    <= sclk_n;
            DATA1   <= data1_n;
            DATA2   <= data2_n;
            DONE    <= done_n;
            BUSY    <= busy_n;
            OVERRUN <= ovr_n;
            FMT_ERR <= fmt_n;
        end
    end
endmodule

// File: tb/tb_dual_adc_capture.sv
// tb_dual_adc_capture: directed frame, error, overrun, reset, back-to-back and parameter checks
module tb_dual_adc_capture;
    logic        clk = 1'b0;
    logic        rst, start, din1, din2;
    logic        ncs, sclk, done, busy, overrun, fmt_err;
    logic [11:0] data1, data2;
    logic        start2, ncs2, sclk2, done2, busy2, ovr2, fmt2;
    logic [11:0] data1_2, data2_2;
    logic [15:0] w1 = '0, w2 = '0;
    int          bit_idx = 0;
    int          total = 0, bad = 0;
    int          n_done = 0, n_ovr = 0, n_fmt = 0, n_low = 0, n_rise = 0;
    logic        sclk_q = 1'b1, ncs_q = 1'b1;

    dual_adc_capture u_dut (
        .CLK(clk), .RST(rst), .START(start), .DIN1(din1), .DIN2(din2),
        .nCS(ncs), .SCLK(sclk), .DATA1(data1), .DATA2(data2), .DONE(done),
        .BUSY(busy), .OVERRUN(overrun), .FMT_ERR(fmt_err)
    );

    dual_adc_capture #(.DIV(2), .QUIET(1)) u_fast (
        .CLK(clk), .RST(rst), .START(start2), .DIN1(1'b0), .DIN2(1'b1),
        .nCS(ncs2), .SCLK(sclk2), .DATA1(data1_2), .DATA2(data2_2), .DONE(done2),
        .BUSY(busy2), .OVERRUN(ovr2), .FMT_ERR(fmt2)
    );

    always #5 clk = ~clk;

    // ADC model: restart on nCS fall, present next MSB-first bit on each SCLK fall
    always @(negedge sclk or negedge ncs) begin
        if (!ncs && sclk) bit_idx = 0;
        else if (!ncs) begin
            din1 = w1[15 - bit_idx];
            din2 = w2[15 - bit_idx];
            bit_idx++;
        end
    end

    always @(negedge clk) begin
        if (done) n_done++;
        if (overrun) n_ovr++;
        if (fmt_err) n_fmt++;
        if (!ncs) n_low++;
        if (sclk && !sclk_q && !ncs_q) n_rise++;
        sclk_q = sclk;
        ncs_q  = ncs;
    end

    task automatic run(input int n, input int s_a, input int s_b, input int r_at, input int snap_k,
                       output int done_at, output int fmt_at, output int ovr_at, output int busy_fall,
                       output logic [3:0] snap, output logic [11:0] snap_d1);
        done_at = -1; fmt_at = -1; ovr_at = -1; busy_fall = -1; snap = 'x; snap_d1 = 'x;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            start = (k == s_a) || (k == s_b);
            rst   = (k == r_at);
            @(negedge clk);
            if (done && done_at < 0) done_at = k;
            if (fmt_err && fmt_at < 0) fmt_at = k;
            if (overrun && ovr_at < 0) ovr_at = k;
            if (!busy && busy_fall < 0) busy_fall = k;
            if (k == snap_k) begin snap = {ncs, sclk, busy, done}; snap_d1 = data1; end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total += 8;
        if (ncs !== 1'b1) begin bad++; $display("FAIL reset_ncs got=%b exp=1", ncs); end
        if (sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk got=%b exp=1", sclk); end
        if (data1 !== 12'h000) begin bad++; $display("FAIL reset_data1 got=%h exp=000", data1); end
        if (data2 !== 12'h000) begin bad++; $display("FAIL reset_data2 got=%h exp=000", data2); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        if (fmt_err !== 1'b0) begin bad++; $display("FAIL reset_fmt got=%b exp=0", fmt_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int d, f, o, b, dn, rs, lo;
        logic [3:0] s;
        logic [11:0] sd;
        w1 = 16'h0ABC; w2 = 16'h0123;
        dn = n_done; rs = n_rise; lo = n_low;
        run(140, -1, -1, -1, 1, d, f, o, b, s, sd);
        total += 9;
        if (s[3:1] !== 3'b011) begin bad++; $display("FAIL basic_start ncs/sclk/busy got=%b exp=011", s[3:1]); end
        if (d != 128) begin bad++; $display("FAIL basic_done_at got=%0d exp=128", d); end
        if (data1 !== 12'hABC) begin bad++; $display("FAIL basic_data1 got=%h exp=abc", data1); end
        if (data2 !== 12'h123) begin bad++; $display("FAIL basic_data2 got=%h exp=123", data2); end
        if (f != -1) begin bad++; $display("FAIL basic_fmt got=%0d exp=-1", f); end
        if (n_done - dn != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", n_done - dn); end
        if (n_rise - rs != 16) begin bad++; $display("FAIL basic_rises got=%0d exp=16", n_rise - rs); end
        if (n_low - lo != 128) begin bad++; $display("FAIL basic_ncs_low got=%0d exp=128", n_low - lo); end
        if (b != 136) begin bad++; $display("FAIL basic_busy_fall got=%0d exp=136", b); end
    endtask

    task automatic test_fmt_err;
        int d, f, o, b;
        logic [3:0] s;
        logic [11:0] sd;
        w1 = 16'h8FFF; w2 = 16'h0000;
        run(140, -1, -1, -1, -1, d, f, o, b, s, sd);
        total += 4;
        if (d != 128) begin bad++; $display("FAIL fmt_done_at got=%0d exp=128", d); end
        if (f != 128) begin bad++; $display("FAIL fmt_at got=%0d exp=128", f); end
        if (data1 !== 12'hFFF) begin bad++; $display("FAIL fmt_data1 got=%h exp=fff", data1); end
        if (data2 !== 12'h000) begin bad++; $display("FAIL fmt_data2 got=%h exp=000", data2); end
    endtask

    task automatic test_overrun;
        int d, f, o, b, dn, ov, lo;
        logic [3:0] s;
        logic [11:0] sd;
        w1 = 16'h0321; w2 = 16'h0654;
        dn = n_done; ov = n_ovr; lo = n_low;
        run(150, 41, 130, -1, -1, d, f, o, b, s, sd);
        total += 6;
        if (o != 41) begin bad++; $display("FAIL ovr_at got=%0d exp=41", o); end
        if (n_ovr - ov != 1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", n_ovr - ov); end
        if (n_done - dn != 1) begin bad++; $display("FAIL ovr_done_count got=%0d exp=1", n_done - dn); end
        if (n_low - lo != 128) begin bad++; $display("FAIL ovr_ncs_low got=%0d exp=128", n_low - lo); end
        if (d != 128) begin bad++; $display("FAIL ovr_done_at got=%0d exp=128", d); end
        if (data1 !== 12'h321) begin bad++; $display("FAIL ovr_data1 got=%h exp=321", data1); end
    endtask

    task automatic test_mid_reset;
        int d, f, o, b, dn;
        logic [3:0] s;
        logic [11:0] sd;
        w1 = 16'h0555; w2 = 16'h0AAA;
        run(140, -1, -1, -1, -1, d, f, o, b, s, sd);
        total += 1;
        if (data1 !== 12'h555) begin bad++; $display("FAIL rst_pre_data1 got=%h exp=555", data1); end
        dn = n_done;
        run(200, 60, -1, 51, 51, d, f, o, b, s, sd);
        total += 6;
        if (s[3:1] !== 3'b110) begin bad++; $display("FAIL rst_ncs/sclk/busy got=%b exp=110", s[3:1]); end
        if (sd !== 12'h000) begin bad++; $display("FAIL rst_data1 got=%h exp=000", sd); end
        if (d != 188) begin bad++; $display("FAIL rst_done_at got=%0d exp=188", d); end
        if (n_done - dn != 1) begin bad++; $display("FAIL rst_done_count got=%0d exp=1", n_done - dn); end
        if (data1 !== 12'h555) begin bad++; $display("FAIL rst_post_data1 got=%h exp=555", data1); end
        if (data2 !== 12'hAAA) begin bad++; $display("FAIL rst_post_data2 got=%h exp=aaa", data2); end
    endtask

    task automatic test_back_to_back;
        int d, f, o, b, dn, ov;
        logic [3:0] s;
        logic [11:0] sd;
        logic [11:0] e1, e2;
        dn = n_done; ov = n_ovr;
        for (int i = 0; i < 4; i++) begin
            e1 = i[0] ? 12'hFFF : 12'h000;
            e2 = ~e1;
            w1 = {4'h0, e1}; w2 = {4'h0, e2};
            run(136, -1, -1, -1, -1, d, f, o, b, s, sd);
            total += 3;
            if (d != 128) begin bad++; $display("FAIL b2b_done_at[%0d] got=%0d exp=128", i, d); end
            if (data1 !== e1) begin bad++; $display("FAIL b2b_data1[%0d] got=%h exp=%h", i, data1, e1); end
            if (data2 !== e2) begin bad++; $display("FAIL b2b_data2[%0d] got=%h exp=%h", i, data2, e2); end
        end
        total += 2;
        if (n_done - dn != 4) begin bad++; $display("FAIL b2b_done_count got=%0d exp=4", n_done - dn); end
        if (n_ovr - ov != 0) begin bad++; $display("FAIL b2b_overrun got=%0d exp=0", n_ovr - ov); end
    endtask

    task automatic test_sweep;
        int d = -1, b = -1, f = -1, r1 = -1, r2 = -1;
        logic sq = 1'b1;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (done2 && d < 0) d = k;
            if (fmt2 && f < 0) f = k;
            if (!busy2 && b < 0) b = k;
            if (sclk2 && !sq && r1 < 0) r1 = k;
            else if (sclk2 && !sq && r2 < 0) r2 = k;
            sq = sclk2;
        end
        total += 6;
        if (d != 64) begin bad++; $display("FAIL sweep_done_at got=%0d exp=64", d); end
        if (b != 65) begin bad++; $display("FAIL sweep_busy_fall got=%0d exp=65", b); end
        if (r1 != 4) begin bad++; $display("FAIL sweep_first_rise got=%0d exp=4", r1); end
        if (r2 - r1 != 4) begin bad++; $display("FAIL sweep_period got=%0d exp=4", r2 - r1); end
        if (f != 64) begin bad++; $display("FAIL sweep_fmt_at got=%0d exp=64", f); end
        if ({data1_2, data2_2} !== 24'h000FFF) begin bad++; $display("FAIL sweep_data got=%h exp=000fff", {data1_2, data2_2}); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; din1 = 1'b0; din2 = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        test_basic;
        test_fmt_err;
        test_overrun;
        test_mid_reset;
        test_back_to_back;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
